// File: rtl/vga_pkg.sv
//==============================================================================
// Module      : vga_pkg
// Description : Shared VGA 640x480@60 timing constants, source-frame defaults
//               and the RGB444 pixel type.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

  localparam int SRC_W_DEFAULT = 320;
  localparam int SRC_H_DEFAULT = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
//==============================================================================
// Module      : vga_delay_line
// Description : WIDTH x DEPTH shift register, synchronous active-low reset to
//               RST_VAL in every stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH*WIDTH-1:0] r_shift;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!reset_n) r_shift <= RST_VAL;
        else          r_shift <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!reset_n) r_shift <= {DEPTH{RST_VAL}};
        else          r_shift <= {r_shift[(DEPTH-1)*WIDTH-1:0], din};
      end
    end
  endgenerate

  assign dout = r_shift[DEPTH*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
//==============================================================================
// Module      : vga_pixel_fetch
// Description : Frame-buffer fetch with 2x pixel/line doubling, sync alignment
//               to the read latency and registered RGB444/sync outputs.
//               Optional colour bars: VGA_FETCH_TESTPATTERN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int SRC_W   = SRC_W_DEFAULT,
  parameter int SRC_H   = SRC_H_DEFAULT,
  parameter int ADDR_W  = 17,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              video_on_in,
  input  logic              frame_ready,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [11:0]       fb_rd_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n
);

  logic w_active;
  logic w_line_end;
  logic w_frame_last;
  logic w_frame_start;

  assign w_active      = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));
  assign w_line_end    = (h_count == 10'(H_TOTAL - 1));
  assign w_frame_last  = (v_count == 10'(V_TOTAL - 1));
  assign w_frame_start = (h_count == 10'd0) && (v_count == 10'd0);

  // Base advances once per pair of display lines, giving line doubling without a multiplier.
  logic [ADDR_W-1:0] r_row_base;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_row_base <= '0;
    end else if (w_line_end) begin
      if (w_frame_last)
        r_row_base <= '0;
      else if (v_count[0] && (v_count < 10'(V_DISPLAY)))
        r_row_base <= r_row_base + ADDR_W'(SRC_W);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
    end else if (w_active) begin
      fb_rd_en   <= 1'b1;
      fb_rd_addr <= r_row_base + ADDR_W'(h_count[9:1]);
    end else begin
      fb_rd_en   <= 1'b0;
    end
  end

  // Sampled only at frame start so a new frame_ready level never tears a frame.
  logic r_show_fb;

  always_ff @(posedge clk) begin
    if (!reset_n)           r_show_fb <= 1'b0;
    else if (w_frame_start) r_show_fb <= frame_ready;
  end

`ifdef VGA_FETCH_TESTPATTERN_EN
  localparam int DL_W = 6;
  localparam logic [DL_W-1:0] DL_RST = 6'b110_000;

  // Bar index is registered once so it carries the same 1-cycle lag as the strobes.
  logic [2:0] r_bar_in;

  always_ff @(posedge clk) begin
    if (!reset_n) r_bar_in <= 3'd0;
    else          r_bar_in <= h_count[8:6];
  end

  logic [DL_W-1:0] w_dl_in;
  assign w_dl_in = {h_sync_in, v_sync_in, video_on_in, r_bar_in};
`else
  localparam int DL_W = 3;
  localparam logic [DL_W-1:0] DL_RST = 3'b110;

  logic [DL_W-1:0] w_dl_in;
  assign w_dl_in = {h_sync_in, v_sync_in, video_on_in};
`endif

  logic [DL_W-1:0] w_dl_out;

  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (RAM_LAT),
    .RST_VAL (DL_RST)
  ) u_align (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (w_dl_in),
    .dout    (w_dl_out)
  );

  logic w_hs_d;
  logic w_vs_d;
  logic w_vo_d;

  assign w_hs_d = w_dl_out[DL_W-1];
  assign w_vs_d = w_dl_out[DL_W-2];
  assign w_vo_d = w_dl_out[DL_W-3];

  rgb444_t w_pix;

  always_comb begin
    w_pix = '0;
    if (w_vo_d) begin
      if (r_show_fb) begin
        w_pix = fb_rd_data;
      end else begin
`ifdef VGA_FETCH_TESTPATTERN_EN
        w_pix.r = {4{w_dl_out[2]}};
        w_pix.g = {4{w_dl_out[1]}};
        w_pix.b = {4{w_dl_out[0]}};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vga_r       <= 4'd0;
      vga_g       <= 4'd0;
      vga_b       <= 4'd0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= w_pix.r;
      vga_g       <= w_pix.g;
      vga_b       <= w_pix.b;
      vga_hs      <= w_hs_d;
      vga_vs      <= w_vs_d;
      vga_blank_n <= w_vo_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Display-side pixel fetch stage, directly downstream of the VGA timing generator. Consumes its pixel counters and sync/blank strobes, turns them into frame-buffer read addresses with 2x pixel/line doubling (320x240 source to 640x480 display), and absorbs the buffer's read latency. It delays the syncs to match and drives registered RGB444 and sync pins to the DAC/connector.

## Interface
Parameters:
- SRC_W, 320, source frame width in pixels
- SRC_H, 240, source frame height in lines
- ADDR_W, 17, frame-buffer address width; must satisfy SRC_W*SRC_H <= 2^ADDR_W
- RAM_LAT, 2, frame-buffer read latency in cycles, from registered address to valid data (1..4)

Ports:
- clk  in  1  25 MHz pixel clock
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- h_count  in  10  current x position from the timing generator (0..799)
- v_count  in  10  current y position (0..524)
- h_sync_in  in  1  registered h-sync, active low; lags h_count/v_count by 1 cycle
- v_sync_in  in  1  registered v-sync, active low; same 1-cycle lag
- video_on_in  in  1  registered active-area flag; same 1-cycle lag
- frame_ready  in  1  level; high once the capture side has written at least one complete frame
- fb_rd_en  out  1  frame-buffer read enable
- fb_rd_addr  out  ADDR_W  frame-buffer read address
- fb_rd_data  in  12  RGB444 read data {R[11:8],G[7:4],B[3:0]}; valid RAM_LAT cycles after the address
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- vga_hs, vga_vs  out  1  syncs to connector, active low
- vga_blank_n  out  1  high in the active area

## Operation
- Active(h,v) = h_count < 640 && v_count < 480.
- Row base register row_base (ADDR_W bits):
  - At h_count==799, add SRC_W when v_count[0]==1 and v_count<480.
  - At h_count==799 with v_count==524, clear to 0. This takes priority over the add.
- Address register: when Active, fb_rd_addr <= row_base + h_count[9:1] and fb_rd_en <= 1. Otherwise fb_rd_en <= 0 and fb_rd_addr holds.
- Address sequence: the address is (v/2)*SRC_W + h/2. The last address in a frame is 76799, at v=479, h=638/639. No multiplier is used.
- Frame gate show_fb:
  - Loads frame_ready at h_count==0 && v_count==0 only.
  - Never changes mid-frame.
- Alignment: h_sync_in, v_sync_in and video_on_in, plus h_count[8:6] when the macro is enabled, pass through a RAM_LAT-stage delay line. The delay line's output meets fb_rd_data at the output register.
- Output register, using the delayed video_on (vo_d):
  - vo_d=0: RGB=0.
  - vo_d=1 and show_fb=1: RGB=fb_rd_data.
  - vo_d=1 and show_fb=0: black, or test bars (see Configuration).
  - vga_hs, vga_vs and vga_blank_n are registered from the delayed strobes in the same edge as RGB.
- Reset: on reset_n=0 at a clock edge, the following take these values:
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0.
  - fb_rd_en=0, fb_rd_addr=0, row_base=0, show_fb=0.
  - All delay stages: hs=1, vs=1, vo=0, bar=0.
- Reset mid-frame while the timing generator keeps running: row_base may be misaligned until v_count reaches 524. This is harmless, because show_fb stays 0 until the next frame start, so only black or bars are shown.
- Changes on frame_ready take effect only at the next frame start, which prevents tearing.

## Timing
- Edge t: counts presented. Edge t+1: fb_rd_addr/fb_rd_en registered. Edge t+1+RAM_LAT: data valid. Edge t+2+RAM_LAT: RGB on pins.
- Sync strobes arrive at t+1. They are delayed RAM_LAT stages plus the output register, so the sync-in to sync-out latency is RAM_LAT+1 cycles. Counter-to-pixel latency is RAM_LAT+2.
- Pixels and syncs leave in the same cycle; the porch widths of the timing generator are preserved exactly.
- There is no backpressure. fb_rd_data is assumed valid every cycle at its latency slot.

## Configuration
- VGA_FETCH_TESTPATTERN_EN defined:
  - With vo_d=1 and show_fb=0, output 8 repeating 64-px bars. k=delayed h_count[8:6]; R=k[2]?F:0, G=k[1]?F:0, B=k[0]?F:0.
  - Result: h 0..63 black, 64..127 blue, … 448..511 white; the pattern repeats from h 512.
- Not defined: the bar logic and the h_count[8:6] delay stages are absent, and the output is black whenever show_fb=0.

## Structure
- Shared package vga_pkg holds:
  - H_DISPLAY/H_FRONT/H_SYNC/H_BACK/H_TOTAL (640/16/96/48/800) and the V equivalents (480/10/2/33/525).
  - SRC_W/SRC_H defaults.
  - An rgb444 struct typedef.
- One sub-module, vga_delay_line: a parameterised width × depth shift register with a synchronous, active-low reset to a parameter value. It is used for the sync/blank/bar alignment.

## Test plan
- Reset held 3 cycles with counts running -> vga_hs=1, vga_vs=1, blank_n=0, RGB=0, fb_rd_en=0; all hold until reset_n=1.
- frame_ready=1 before frame start, RAM model returns data=addr[11:0], RAM_LAT=2 -> at (h=5,v=3), fb_rd_addr=322 one edge later; RGB=0x142 four edges after the counts; v=479/h=639 yields address 76799.
- Sync alignment -> vga_hs low for exactly 96 cycles and vga_vs low for exactly 2 lines, each lagging h_sync_in/v_sync_in by 3 cycles (RAM_LAT=2); blank_n high for exactly 640 cycles per line on 480 lines.
- frame_ready toggled 0→1 at v=200 -> current frame stays black/bars; fb data appears from the first pixel of the next frame.
- Macro defined, frame_ready=0 -> pixel at h=64 is 0x00F, h=448 is 0xFFF, h=512 is 0x000; without the macro all pixels are 0x000.
- Reset pulsed at v=300 while the timing generator runs -> output is black until frame start, then the next frame's addresses begin at 0 and match the expected sequence.
